// File: rtl/alu_slice_seq.sv
// Multi-cycle 74181-style ALU: processes SLICE bits per clock, LSB slice first,
// with a registered ripple carry and a valid/ready handshake on both sides.
module alu_slice_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             aeb,
    output logic             zero,
    output logic             ovf
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_bad_params
        $error("alu_slice_seq: WIDTH must be a non-zero multiple of SLICE");
    end

    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cout_q, cout_d;
    logic             aeb_q, aeb_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [SLICE-1:0] a_sl, b_sl, r_sl;
    logic             c_rip, c_msb, c_out;
    logic             x_bit, y_bit;

    // Current slice of the function generator, rippling from the carry register.
    always_comb begin : slice_alu
        a_sl  = SLICE'(a_q >> (SLICE * int'(k_q)));
        b_sl  = SLICE'(b_q >> (SLICE * int'(k_q)));
        c_rip = carry_q;
        c_msb = 1'b0;
        r_sl  = '0;
        x_bit = 1'b0;
        y_bit = 1'b0;
        for (int j = 0; j < int'(SLICE); j++) begin
            x_bit = a_sl[j] | (b_sl[j] & s_q[0]) | (~b_sl[j] & s_q[1]);
            y_bit = (a_sl[j] & b_sl[j] & s_q[3]) | (a_sl[j] & ~b_sl[j] & s_q[2]);
            if (j == int'(SLICE) - 1) begin
                c_msb = c_rip;
            end
            if (m_q) begin
                r_sl[j] = ~(x_bit ^ y_bit);
            end else begin
                r_sl[j] = x_bit ^ y_bit ^ c_rip;
                c_rip   = (x_bit & y_bit) | (c_rip & (x_bit ^ y_bit));
            end
        end
        c_out = m_q ? 1'b0 : c_rip;
    end

    always_comb begin : next_state
        state_d     = state_q;
        k_d         = k_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        m_d         = m_q;
        f_d         = f_q;
        cout_d      = cout_q;
        aeb_d       = aeb_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            BUSY: begin
                f_d[SLICE * int'(k_q) +: SLICE] = r_sl;
                carry_d = c_out;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    // Flags are taken from the completed result on entry to DONE.
                    state_d     = DONE;
                    k_d         = '0;
                    cout_d      = c_out;
                    ovf_d       = m_q ? 1'b0 : (c_msb ^ c_out);
                    aeb_d       = &f_d;
                    zero_d      = ~|f_d;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept from IDLE, or overlapped with the result handshake in DONE.
        if (in_valid && in_ready) begin
            state_d = BUSY;
            k_d     = '0;
            carry_d = m ? 1'b0 : cin;
            a_d     = a;
            b_d     = b;
            s_d     = s;
            m_d     = m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            m_q         <= 1'b0;
            f_q         <= '0;
            cout_q      <= 1'b0;
            aeb_q       <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            m_q         <= m_d;
            f_q         <= f_d;
            cout_q      <= cout_d;
            aeb_q       <= aeb_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign f         = f_q;
    assign cout      = cout_q;
    assign aeb       = aeb_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Self-checking bench for alu_slice_seq: directed spec cases plus randomized
// traffic, checked against a whole-word arithmetic reference model.
module tb_alu_slice_seq;
    localparam int W      = 16;
    localparam int NSLICE = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [3:0]   s;
    logic         m, cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f;
    logic         cout, aeb, zero, ovf;

    typedef struct {
        logic [W-1:0] f;
        logic         cout;
        logic         aeb;
        logic         zero;
        logic         ovf;
        int           acc;
        bit           seen;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    alu_slice_seq #(.WIDTH(W), .SLICE(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s(s), .m(m), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .cout(cout), .aeb(aeb), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Whole-word reference: X/Y per the function table, then one wide add.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic [3:0] sv, input logic mv, input logic cv);
        exp_t         r;
        logic [W-1:0] x, y;
        logic [W:0]   sum;
        logic [W-1:0] low;
        x = av | (bv & {W{sv[0]}}) | (~bv & {W{sv[1]}});
        y = (av & bv & {W{sv[3]}}) | (av & ~bv & {W{sv[2]}});
        r.acc  = 0;
        r.seen = 1'b0;
        if (mv) begin
            r.f    = ~(x ^ y);
            r.cout = 1'b0;
            r.ovf  = 1'b0;
        end else begin
            sum    = {1'b0, x} + {1'b0, y} + (W+1)'(cv);
            low    = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + W'(cv);
            r.f    = sum[W-1:0];
            r.cout = sum[W];
            r.ovf  = low[W-1] ^ sum[W];
        end
        r.aeb  = &r.f;
        r.zero = (r.f == '0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle scoreboard compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("sb_f",    32'(f),    32'(exp_q[0].f));
                    chk("sb_cout", 32'(cout), 32'(exp_q[0].cout));
                    chk("sb_aeb",  32'(aeb),  32'(exp_q[0].aeb));
                    chk("sb_zero", 32'(zero), 32'(exp_q[0].zero));
                    chk("sb_ovf",  32'(ovf),  32'(exp_q[0].ovf));
                    if (!exp_q[0].seen) begin
                        chk("sb_latency", 32'(cyc - exp_q[0].acc), 32'(NSLICE + 1));
                        exp_q[0].seen = 1'b1;
                    end
                end
                chk("sb_in_ready_done", 32'(in_ready), 32'(out_ready));
                if (out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e     = model(a, b, s, m, cin);
                e.acc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [3:0] sv, input logic mv, input logic cv);
        in_valid = 1'b1;
        a = av; b = bv; s = sv; m = mv; cin = cv;
    endtask

    task automatic scramble();
        a = W'($urandom); b = W'($urandom); s = 4'($urandom);
        m = 1'($urandom); cin = 1'($urandom);
    endtask

    task automatic check_result(input string nm, input logic [W-1:0] ef, input logic ec,
                                input logic ea, input logic ez, input logic eo);
        chk({nm, "_f"},    32'(f),    32'(ef));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_aeb"},  32'(aeb),  32'(ea));
        chk({nm, "_zero"}, 32'(zero), 32'(ez));
        chk({nm, "_ovf"},  32'(ovf),  32'(eo));
    endtask

    task automatic run_dir(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [3:0] sv, input logic mv, input logic cv,
                           input logic [W-1:0] ef, input logic ec, input logic ea,
                           input logic ez, input logic eo);
        exp_t md;
        int   n;
        md = model(av, bv, sv, mv, cv);
        chk({nm, "_model"}, 32'({md.f, md.cout, md.aeb, md.zero, md.ovf}),
            32'({ef, ec, ea, ez, eo}));
        @(posedge clk); #1;
        drive(av, bv, sv, mv, cv);
        out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_accept"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        wait_out(n);
        chk({nm, "_latency"}, 32'(n), 32'(NSLICE));
        check_result(nm, ef, ec, ea, ez, eo);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_result("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);

        run_dir("add",     16'h1234, 16'h0FFF, 4'd9, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
        run_dir("sub_pos", 16'h0007, 16'h0005, 4'd6, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        run_dir("sub_neg", 16'h0005, 16'h0007, 4'd6, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_dir("cmp_eq",  16'h5A5A, 16'h5A5A, 4'd6, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_dir("ovf",     16'h7FFF, 16'h0001, 4'd9, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_dir("xor",     16'hF0F0, 16'hFF00, 4'd6, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_dir("logic0",  16'hF0F0, 16'hFF00, 4'd3, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        run_dir("nota",    16'h1234, 16'h5555, 4'd0, 1'b1, 1'b0, 16'hEDCB, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure: hold result in DONE, then overlap the next accept.
        @(posedge clk); #1;
        drive(16'h1111, 16'h2222, 4'd9, 1'b0, 1'b0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(n);
        chk("bp_latency", 32'(n), 32'(NSLICE));
        drive(16'hAAAA, 16'h5555, 4'd9, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_f",        32'(f),         32'h3333);
            chk("bp_hold_valid",    32'(out_valid), 32'd1);
            chk("bp_hold_in_ready", 32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        drive(16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_overlap_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        wait_out(n);
        chk("bp2_latency", 32'(n), 32'(NSLICE));
        check_result("bp2", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Reset during the second BUSY cycle aborts the op.
        drive(16'hFFFF, 16'hFFFF, 4'd9, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_result("abort", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_dir("post_rst", 16'h0001, 16'h0001, 4'd9, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with random backpressure.
        repeat (800) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            scramble();
            if ($urandom_range(0, 7) == 0) b = a;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
